rf_read_arbiter: RTL and testbench

Shares the single read port of the register file (the 32:1 read multiplexer and its select) among NREQ requesters. It arbitrates round-robin, drives the multiplexer select, captures the selected register, and returns it with a valid/ready handshake tagged with the requester id. Optional write bypass keeps a read coherent with a write landing in the same cycle. It sits between the pipeline read clients and the register file.

---
 rtl/rf_pkg.sv | 9 +
 rtl/rf_read_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/rf_read_arbiter.sv | 56 +++++
 tb/tb_rf_read_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file defaults, read-arbiter state enum and id-width helper
package rf_pkg;
    localparam int WIDTH = 32;
    localparam int SIZE  = 5;
    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rf_read_arbiter_if.sv
// rf_read_arbiter_if: request, register-file read port, write snoop and response bundle
import rf_pkg::*;
interface rf_read_arbiter_if #(
    parameter int WIDTH = rf_pkg::WIDTH,
    parameter int SIZE  = rf_pkg::SIZE,
    parameter int NREQ  = 4
);
    localparam int IDW = id_w(NREQ);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SIZE-1:0] req_addr;
    logic [NREQ-1:0]      req_ready;
    logic [SIZE-1:0]      rf_select;
    logic [WIDTH-1:0]     rf_data;
    logic                 wr_en;
    logic [SIZE-1:0]      wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [WIDTH-1:0]     rsp_data;
    logic [NREQ-1:0]      rsp_ready;
    modport slave (
        input  req_valid, req_addr, rf_data, wr_en, wr_addr, wr_data, rsp_ready,
        output req_ready, rf_select, rsp_valid, rsp_id, rsp_data
    );
    modport master (
        output req_valid, req_addr, rf_data, wr_en, wr_addr, wr_data, rsp_ready,
        input  req_ready, rf_select, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after ptr, grant gated by en
import rf_pkg::*;
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    logic [IDW-1:0] c;
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            c = IDW'((int'(ptr) + k) % NREQ);
            if (!any && req[c]) begin
                any = 1'b1;
                idx = c;
            end
        end
        gnt[idx] = en & any;
    end
endmodule

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: round-robin sharing of the register-file read port with optional write bypass
import rf_pkg::*;
module rf_read_arbiter #(
    parameter int WIDTH  = rf_pkg::WIDTH,
    parameter int SIZE   = rf_pkg::SIZE,
    parameter int NREQ   = 4,
    parameter bit BYPASS = 1'b1
) (
    input logic clk,
    input logic reset,
    rf_read_arbiter_if.slave bus
);
    localparam int IDW = id_w(NREQ);
    state_t           state, state_n;
    logic [IDW-1:0]   ptr, id_q, win;
    logic [SIZE-1:0]  addr_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [NREQ-1:0]  gnt;
    logic             window, any;
    // grants open in IDLE, or in RESP on the cycle the owner takes the response
    assign window = !reset && (state == IDLE || (state == RESP && bus.rsp_ready[id_q]));
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req(bus.req_valid),
        .ptr(ptr),
        .en (window),
        .gnt(gnt),
        .idx(win),
        .any(any)
    );
    always_comb begin
        state_n = window ? (any ? READ : IDLE) : (state == READ ? RESP : state);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= IDW'(NREQ - 1);
            id_q       <= '0;
            addr_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            state <= state_n;
            if (window && any) begin
                addr_q <= bus.req_addr[win*SIZE +: SIZE];
                id_q   <= win;
                ptr    <= win;
            end
            if (state == READ)
                rsp_data_q <= (BYPASS && bus.wr_en && bus.wr_addr == addr_q) ? bus.wr_data : bus.rf_data;
        end
    end
    assign bus.req_ready = gnt;
    assign bus.rf_select = addr_q;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_rf_read_arbiter.sv
// tb_rf_read_arbiter: directed vectors for the register-file read arbiter, BYPASS=1 and BYPASS=0 side by side
module tb_rf_read_arbiter;
    logic clk, reset;
    int   nvec = 0, nerr = 0;
    rf_read_arbiter_if #(.WIDTH(32), .SIZE(5), .NREQ(4)) b ();
    rf_read_arbiter_if #(.WIDTH(32), .SIZE(5), .NREQ(4)) b0 ();
    rf_read_arbiter #(.WIDTH(32), .SIZE(5), .NREQ(4), .BYPASS(1'b1)) dut (.clk(clk), .reset(reset), .bus(b));
    rf_read_arbiter #(.WIDTH(32), .SIZE(5), .NREQ(4), .BYPASS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    logic [31:0] rf [32] = '{default: 32'h0};
    always @(posedge clk) if (b.wr_en) rf[b.wr_addr] <= b.wr_data;
    assign b.rf_data    = rf[b.rf_select];
    assign b0.rf_data   = rf[b0.rf_select];
    assign b0.req_valid = b.req_valid;
    assign b0.req_addr  = b.req_addr;
    assign b0.wr_en     = b.wr_en;
    assign b0.wr_addr   = b.wr_addr;
    assign b0.wr_data   = b.wr_data;
    assign b0.rsp_ready = b.rsp_ready;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic go();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        b.wr_en = 1'b1; b.wr_addr = a; b.wr_data = d;
        go();
        b.wr_en = 1'b0;
    endtask
    task automatic set_addr(input int i, input logic [4:0] a);
        b.req_addr[i*5 +: 5] = a;
    endtask
    initial begin
        reset = 1'b0; b.req_valid = 4'hF; b.req_addr = '0; b.rsp_ready = '0;
        b.wr_en = 1'b0; b.wr_addr = '0; b.wr_data = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ready", 32'(b.req_ready), 0);
        chk("rst_valid", 32'(b.rsp_valid), 0);
        chk("rst_id", 32'(b.rsp_id), 0);
        chk("rst_data", b.rsp_data, 0);
        chk("rst_sel", 32'(b.rf_select), 0);
        b.req_valid = '0;
        go();
        reset = 1'b0;
        wr(5'd7, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) wr(5'(8 + i), 32'h100 + 32'(i));
        // single request from requester 2
        set_addr(2, 5'd7);
        b.req_valid = 4'b0100;
        #1;
        chk("single_gnt", 32'(b.req_ready), 32'b0100);
        go();
        b.req_valid = '0;
        #1;
        chk("single_sel", 32'(b.rf_select), 7);
        chk("single_read_ready", 32'(b.req_ready), 0);
        chk("single_read_valid", 32'(b.rsp_valid), 0);
        go();
        chk("single_valid", 32'(b.rsp_valid), 1);
        chk("single_id", 32'(b.rsp_id), 2);
        chk("single_data", b.rsp_data, 32'hDEADBEEF);
        b.rsp_ready = 4'b0100;
        go();
        chk("single_done", 32'(b.rsp_valid), 0);
        // full load from a fresh reset
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) set_addr(i, 5'(8 + i));
        b.req_valid = 4'hF; b.rsp_ready = 4'hF;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("rr_gnt", 32'(b.req_ready), 32'(1 << (k % 4)));
            if (k > 0) begin
                chk("rr_id", 32'(b.rsp_id), 32'((k - 1) % 4));
                chk("rr_data", b.rsp_data, 32'h100 + 32'((k - 1) % 4));
            end
            go();
            chk("rr_sel", 32'(b.rf_select), 32'(8 + k % 4));
            chk("rr_read_ready", 32'(b.req_ready), 0);
            go();
        end
        b.req_valid = '0;
        #1;
        chk("rr_last_id", 32'(b.rsp_id), 1);
        chk("rr_last_data", b.rsp_data, 32'h101);
        go();
        chk("rr_idle", 32'(b.rsp_valid), 0);
        // backpressure on requester 1
        b.req_valid = 4'b0010; b.rsp_ready = 4'b1101;
        #1;
        chk("bp_gnt", 32'(b.req_ready), 32'b0010);
        go();
        b.req_valid = 4'hF;
        go();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(b.rsp_valid), 1);
            chk("bp_id", 32'(b.rsp_id), 1);
            chk("bp_data", b.rsp_data, 32'h101);
            chk("bp_nogrant", 32'(b.req_ready), 0);
            go();
        end
        b.rsp_ready = 4'hF;
        #1;
        chk("bp_resume", 32'(b.req_ready), 32'b0100);
        go();
        chk("bp_sel", 32'(b.rf_select), 10);
        b.req_valid = '0;
        go();
        chk("bp_next_id", 32'(b.rsp_id), 2);
        chk("bp_next_data", b.rsp_data, 32'h102);
        go();
        // same-cycle write bypass, then write during RESP
        b.rsp_ready = '0;
        set_addr(0, 5'd5);
        b.req_valid = 4'b0001;
        #1;
        chk("byp_gnt", 32'(b.req_ready), 32'b0001);
        go();
        b.req_valid = '0;
        b.wr_en = 1'b1; b.wr_addr = 5'd5; b.wr_data = 32'h12345678;
        go();
        b.wr_en = 1'b0;
        chk("byp_on", b.rsp_data, 32'h12345678);
        chk("byp_off", b0.rsp_data, 32'h0);
        chk("byp_id", 32'(b.rsp_id), 0);
        b.wr_en = 1'b1; b.wr_addr = 5'd5; b.wr_data = 32'hCAFEF00D;
        go();
        b.wr_en = 1'b0;
        chk("snap_on", b.rsp_data, 32'h12345678);
        chk("snap_off", b0.rsp_data, 32'h0);
        chk("snap_valid", 32'(b.rsp_valid), 1);
        b.rsp_ready = 4'hF;
        go();
        // asynchronous reset while a response is pending
        b.rsp_ready = '0;
        b.req_valid = 4'hF;
        #1;
        chk("mid_gnt", 32'(b.req_ready), 32'b0010);
        go();
        go();
        chk("mid_valid", 32'(b.rsp_valid), 1);
        chk("mid_id", 32'(b.rsp_id), 1);
        chk("mid_data", b.rsp_data, 32'h101);
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(b.rsp_valid), 0);
        chk("arst_id", 32'(b.rsp_id), 0);
        chk("arst_data", b.rsp_data, 0);
        chk("arst_sel", 32'(b.rf_select), 0);
        chk("arst_ready", 32'(b.req_ready), 0);
        go();
        reset = 1'b0;
        #1;
        chk("post_gnt", 32'(b.req_ready), 32'b0001);
        go();
        chk("post_sel", 32'(b.rf_select), 5);
        chk("post_valid", 32'(b.rsp_valid), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
